prog_uart_tx: RTL and testbench

PROG_UART_TX -- requirements
Module: prog_uart_tx

---
 rtl/prog_uart_pkg.sv | 34 +++
 rtl/prog_uart_tx_byte.sv | 136 +++++++++++++
 rtl/prog_uart_tx.sv | 89 ++++++++
 tb/tb_prog_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_uart_pkg.sv
// Shared FSM encoding, constants and bit helpers for prog_uart_tx.
// PROG_TX_PARITY_EN adds the PARITY state (even parity after each byte).
package prog_uart_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int DIV_W         = 16;

`ifdef PROG_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } tx_state_t;
`endif

    function automatic logic even_parity(input logic [BITS_PER_BYTE-1:0] d);
        return ^d;
    endfunction

    // A divisor of zero would stall the bit counter, so it behaves as one.
    function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/prog_uart_tx_byte.sv
// uart_tx_byte: serializes one byte as start, 8 data bits (LSB first), optional
// parity (PROG_TX_PARITY_EN) and STOP_BITS stop bits; a new byte may chain on the last stop cycle.
module uart_tx_byte
    import prog_uart_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [BITS_PER_BYTE-1:0] byte_i,
    input  logic [DIV_W-1:0]         div_i,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic                     last_o
);

    tx_state_t                r_state;
    logic [DIV_W-1:0]         r_cnt;
    logic [2:0]               r_bit_idx;
    logic                     r_stop_idx;
    logic [BITS_PER_BYTE-1:0] r_shift;
    logic                     r_tx;
    logic                     r_busy;
`ifdef PROG_TX_PARITY_EN
    logic                     r_parity;
`endif

    logic w_bit_end;
    logic w_load;

    assign w_bit_end = (r_cnt == 16'd0);
    assign last_o    = (r_state == STOP) && w_bit_end && (r_stop_idx == 1'(STOP_BITS - 1));
    assign w_load    = start_i && ((r_state == IDLE) || last_o);
    assign tx_o      = r_tx;
    assign busy_o    = r_busy;

    // Bit-level FSM: each bit is held for div_i cycles by the down counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef PROG_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (w_load) begin
            r_state    <= START;
            r_tx       <= 1'b0;
            r_cnt      <= div_i - 16'd1;
            r_shift    <= byte_i;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_busy     <= 1'b1;
`ifdef PROG_TX_PARITY_EN
            r_parity   <= even_parity(byte_i);
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= 3'd0;
                        r_cnt     <= div_i - 16'd1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= div_i - 16'd1;
                        if (r_bit_idx == 3'(BITS_PER_BYTE - 1)) begin
`ifdef PROG_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state    <= STOP;
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`ifdef PROG_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= STOP;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_cnt      <= div_i - 16'd1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                            r_cnt      <= div_i - 16'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_uart_tx.sv
// prog_uart_tx: accepts 32-bit words and sends BYTES_PER_WORD bytes LSB first
// through uart_tx_byte. Optional parity is enabled with PROG_TX_PARITY_EN.
module prog_uart_tx
    import prog_uart_pkg::*;
#(
    parameter int STOP_BITS      = 1,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] clks_per_bit_i,
    input  logic        word_valid_i,
    input  logic [31:0] word_i,
    output logic        word_ready_o,
    output logic        tx_o,
    output logic        tx_busy_o,
    output logic        done_o
);

    logic [31:0]      r_word;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_byte_idx;
    logic             r_active;
    logic             r_ready;
    logic             r_done;

    logic                     w_accept;
    logic                     w_byte_last;
    logic                     w_word_last;
    logic                     w_start;
    logic [BITS_PER_BYTE-1:0] w_byte;
    logic [DIV_W-1:0]         w_div;
    logic                     w_tx;
    logic                     w_busy;

    assign w_accept    = word_valid_i && r_ready;
    assign w_word_last = w_byte_last && (r_byte_idx == 2'(BYTES_PER_WORD - 1));
    assign w_start     = w_accept || (w_byte_last && !w_word_last);
    // r_word is shifted down after each byte, so the following byte sits in [15:8].
    assign w_byte      = w_accept ? word_i[7:0] : r_word[15:8];
    assign w_div       = w_accept ? eff_divisor(clks_per_bit_i) : r_div;

    uart_tx_byte #(
        .STOP_BITS (STOP_BITS)
    ) u_byte (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (w_start),
        .byte_i  (w_byte),
        .div_i   (w_div),
        .tx_o    (w_tx),
        .busy_o  (w_busy),
        .last_o  (w_byte_last)
    );

    // Word latching, byte sequencing, ready and completion pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word     <= 32'd0;
            r_div      <= 16'd1;
            r_byte_idx <= 2'd0;
            r_active   <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word     <= word_i;
                r_div      <= eff_divisor(clks_per_bit_i);
                r_byte_idx <= 2'd0;
                r_active   <= 1'b1;
            end else if (w_word_last) begin
                r_active <= 1'b0;
            end else if (w_byte_last) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_word     <= r_word >> 8;
            end else begin
                r_active <= r_active;
            end
            r_ready <= !w_accept && (w_word_last || !r_active);
            r_done  <= w_word_last;
        end
    end

    assign word_ready_o = r_ready;
    assign done_o       = r_done;
    assign tx_o         = w_tx;
    assign tx_busy_o    = w_busy;

endmodule

// File: tb/tb_prog_uart_tx.sv
// Self-checking bench for prog_uart_tx: table vectors, corner sequences and random
// words compared against a per-cycle waveform model built from the framing rules.
module tb_prog_uart_tx;

    localparam int STOP_BITS = 1;
    localparam int BPW       = 4;
`ifdef PROG_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + 8 + PAR_BITS + STOP_BITS;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic [15:0] clks_per_bit_i = 16'd0;
    logic        word_valid_i = 1'b0;
    logic [31:0] word_i = 32'd0;
    logic        word_ready_o;
    logic        tx_o;
    logic        tx_busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic cap_q[$];
    int   done_at;

    typedef struct {
        logic [31:0] word;
        logic [15:0] div;
        int          exp_bit;
    } vec_t;

    prog_uart_tx #(
        .STOP_BITS      (STOP_BITS),
        .BYTES_PER_WORD (BPW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clks_per_bit_i (clks_per_bit_i),
        .word_valid_i   (word_valid_i),
        .word_i         (word_i),
        .word_ready_o   (word_ready_o),
        .tx_o           (tx_o),
        .tx_busy_o      (tx_busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_bits(input logic v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    // Expected line level for every cycle after acceptance, straight from the frame rules.
    task automatic build_exp(input logic [31:0] w, input logic [15:0] div);
        int d;
        logic [7:0] b;
        d = (div == 16'd0) ? 1 : int'(div);
        exp_q.delete();
        for (int i = 0; i < BPW; i++) begin
            b = w[8*i +: 8];
            push_bits(1'b0, d);
            for (int j = 0; j < 8; j++) push_bits(b[j], d);
`ifdef PROG_TX_PARITY_EN
            push_bits(^b, d);
`endif
            for (int s = 0; s < STOP_BITS; s++) push_bits(1'b1, d);
        end
    endtask

    task automatic start_word(input logic [31:0] w, input logic [15:0] d);
        word_i = w;
        clks_per_bit_i = d;
        word_valid_i = 1'b1;
        check("ready_at_offer", {31'd0, word_ready_o}, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_word(input string name, input logic [31:0] w, input logic [15:0] d,
                              input bit keep, input logic [15:0] chg);
        int n;
        int bad_at;
        int ctl_bad;
        build_exp(w, d);
        n = exp_q.size();
        cap_q.delete();
        done_at = 0;
        bad_at = -1;
        ctl_bad = 0;
        for (int k = 0; k < n; k++) begin
            if (k == 0 && !keep) word_valid_i = 1'b0;
            if (k == n / 2) begin
                word_i = $urandom;
                clks_per_bit_i = chg;
            end
            cap_q.push_back(tx_o);
            if (tx_o !== exp_q[k] && bad_at < 0) bad_at = k;
            if (done_o === 1'b1 && done_at == 0) done_at = k + 1;
            if (tx_busy_o !== 1'b1 || word_ready_o !== 1'b0) ctl_bad++;
            @(negedge clk);
        end
        if (done_o === 1'b1 && done_at == 0) done_at = n + 1;
        check({name, "_wave_first_bad_cycle"}, bad_at, -1);
        check({name, "_busy_ready_during"}, ctl_bad, 32'd0);
        check({name, "_done_cycle"}, done_at, n + 1);
        check({name, "_idle_tx"}, {31'd0, tx_o}, 32'd1);
        check({name, "_idle_ready"}, {31'd0, word_ready_o}, 32'd1);
        check({name, "_idle_busy"}, {31'd0, tx_busy_o}, 32'd0);
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, "_done_cleared"}, {31'd0, done_o}, 32'd0);
        check({name, "_still_ready"}, {31'd0, word_ready_o}, 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [9:0] pat;
        logic [31:0] w;
        logic [15:0] d;
        int mism;
        bit c;

        vecs[0] = '{32'hA5C30F01, 16'd4, 4};
        vecs[1] = '{32'h000000FF, 16'd0, 1};
        vecs[2] = '{32'h00000001, 16'd2, 2};
        vecs[3] = '{32'h12345678, 16'd1, 1};
        vecs[4] = '{32'hFFFFFFFF, 16'd3, 3};
        vecs[5] = '{32'h00000000, 16'd5, 5};

        #1 rst_ni = 1'b0;
        #3;
        check("rst_tx", {31'd0, tx_o}, 32'd1);
        check("rst_ready", {31'd0, word_ready_o}, 32'd0);
        check("rst_busy", {31'd0, tx_busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, word_ready_o}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            start_word(vecs[i].word, vecs[i].div);
            check_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].div, 1'b0, 16'd7);
            check($sformatf("vec%0d_len", i), done_at, BPW * FRAME_BITS * vecs[i].exp_bit + 1);
            idle_check($sformatf("vec%0d", i));
        end

        // Divisor 4: byte 0 = 0x01 is 0,1,0,0,0,0,0,0,0,1 with 4 cycles per bit.
        start_word(32'hA5C30F01, 16'd4);
        check_word("div4", 32'hA5C30F01, 16'd4, 1'b0, 16'd9);
        pat = 10'b10_0000_0010;
        mism = 0;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 4; j++)
                if (cap_q[4*i+j] !== pat[i]) mism++;
        check("div4_byte0_bits", mism, 32'd0);
`ifdef PROG_TX_PARITY_EN
        check("div4_done_at", done_at, 32'd177);
`else
        check("div4_done_at", done_at, 32'd161);
`endif
        idle_check("div4");

        start_word(32'h000000FF, 16'd0);
        check_word("div0", 32'h000000FF, 16'd0, 1'b0, 16'd0);
        mism = 0;
        for (int i = 1; i <= 8; i++) if (cap_q[i] !== 1'b1) mism++;
        check("div0_data_ones", mism, 32'd0);
`ifdef PROG_TX_PARITY_EN
        check("div0_done_at", done_at, 32'd45);
`else
        check("div0_done_at", done_at, 32'd41);
`endif
        idle_check("div0");

`ifdef PROG_TX_PARITY_EN
        start_word(32'h00000001, 16'd2);
        check_word("par", 32'h00000001, 16'd2, 1'b0, 16'd3);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("par_bit_byte%0d", b), {31'd0, cap_q[(b*11+9)*2]}, (b == 0) ? 32'd1 : 32'd0);
            check($sformatf("par_bit2_byte%0d", b), {31'd0, cap_q[(b*11+9)*2+1]}, (b == 0) ? 32'd1 : 32'd0);
        end
        check("par_done_at", done_at, 32'd89);
        idle_check("par");
`endif

        // Back-to-back words with valid held high.
        w = $urandom;
        start_word(w, 16'd3);
        check_word("b2b_1", w, 16'd3, 1'b1, 16'd3);
        w = $urandom;
        start_word(w, 16'd2);
        check("b2b_start_after_done", {31'd0, tx_o}, 32'd0);
        check_word("b2b_2", w, 16'd2, 1'b0, 16'd2);
        idle_check("b2b");

        // Divisor changes mid-word: current word keeps 4, the next uses 8.
        w = $urandom;
        start_word(w, 16'd4);
        check_word("chg_1", w, 16'd4, 1'b0, 16'd8);
        w = $urandom;
        start_word(w, 16'd8);
        check_word("chg_2", w, 16'd8, 1'b0, 16'd1);
        check("chg_2_len", done_at, BPW * FRAME_BITS * 8 + 1);
        idle_check("chg");

        // Reset in the middle of byte 2.
        start_word(32'h5A5A3C3C, 16'd2);
        word_valid_i = 1'b0;
        repeat (2 * FRAME_BITS * 2 + 3) @(negedge clk);
        check("pre_rst_busy", {31'd0, tx_busy_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx_o}, 32'd1);
        check("midrst_ready", {31'd0, word_ready_o}, 32'd0);
        check("midrst_busy", {31'd0, tx_busy_o}, 32'd0);
        check("midrst_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("midrst_ready_next", {31'd0, word_ready_o}, 32'd1);
        mism = 0;
        repeat (60) begin
            if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || done_o !== 1'b0) mism++;
            @(negedge clk);
        end
        check("midrst_no_residual", mism, 32'd0);

        for (int r = 0; r < 8; r++) begin
            w = $urandom;
            d = 16'($urandom_range(0, 5));
            c = ($urandom_range(0, 1) == 1) && (r < 7);
            start_word(w, d);
            check_word($sformatf("rnd%0d", r), w, d, c, 16'($urandom_range(0, 9)));
            if (!c) idle_check($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
